// File: rtl/verificador_micro_tabuleiro_pkg.sv
// Shared definitions for the micro board checker: cell codes,
// FSM state codes and the table of the 8 winning lines.
package verificador_micro_tabuleiro_pkg;

  localparam int CELULA_W = 2;
  localparam int NUM_CEL  = 9;
  localparam int NUM_LIN  = 8;

  localparam logic [CELULA_W-1:0] CELULA_VAZIA    = 2'b00;
  localparam logic [CELULA_W-1:0] CELULA_X        = 2'b01;
  localparam logic [CELULA_W-1:0] CELULA_O        = 2'b10;
  localparam logic [CELULA_W-1:0] CELULA_INVALIDA = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LEITURA = 3'd1,
    CAPTURA = 3'd2,
    AVALIA  = 3'd3,
    FIM     = 3'd4
  } estado_t;

  typedef logic [CELULA_W-1:0] celula_t;
  typedef celula_t [NUM_CEL-1:0] banco_t;

  localparam int LINHAS [NUM_LIN][3] = '{
    '{0, 1, 2},
    '{3, 4, 5},
    '{6, 7, 8},
    '{0, 3, 6},
    '{1, 4, 7},
    '{2, 5, 8},
    '{0, 4, 8},
    '{2, 4, 6}
  };

  // Invalid cells (11) are treated as empty everywhere.
  function automatic logic ocupada(celula_t c);
    return (c == CELULA_X) || (c == CELULA_O);
  endfunction

endpackage

// File: rtl/verificador_micro_tabuleiro_verifica_linhas.sv
// Combinational line evaluation of one 3x3 board: win, draw and
// winning symbol, with the mover's symbol preferred on corrupt boards.
module verifica_linhas
  import verificador_micro_tabuleiro_pkg::*;
(
  input  banco_t  i_celulas,
  input  logic    i_jogador,
  output logic    o_vencida,
  output logic    o_empatada,
  output celula_t o_vencedor
);

  logic w_ganha_x;
  logic w_ganha_o;
  logic w_cheio;

  always_comb begin
    w_ganha_x = 1'b0;
    w_ganha_o = 1'b0;
    w_cheio   = 1'b1;
    for (int l = 0; l < NUM_LIN; l++) begin
      if (i_celulas[LINHAS[l][0]] == CELULA_X &&
          i_celulas[LINHAS[l][1]] == CELULA_X &&
          i_celulas[LINHAS[l][2]] == CELULA_X)
        w_ganha_x = 1'b1;
      if (i_celulas[LINHAS[l][0]] == CELULA_O &&
          i_celulas[LINHAS[l][1]] == CELULA_O &&
          i_celulas[LINHAS[l][2]] == CELULA_O)
        w_ganha_o = 1'b1;
    end
    for (int i = 0; i < NUM_CEL; i++) begin
      if (!ocupada(i_celulas[i]))
        w_cheio = 1'b0;
    end
  end

  always_comb begin
    o_vencedor = CELULA_VAZIA;
    if (i_jogador && w_ganha_o)
      o_vencedor = CELULA_O;
    else if (!i_jogador && w_ganha_x)
      o_vencedor = CELULA_X;
    else if (w_ganha_x)
      o_vencedor = CELULA_X;
    else if (w_ganha_o)
      o_vencedor = CELULA_O;
  end

  assign o_vencida  = w_ganha_x | w_ganha_o;
  assign o_empatada = w_cheio & ~(w_ganha_x | w_ganha_o);

endmodule

// File: rtl/verificador_micro_tabuleiro.sv
// Reads back one micro board (9 cells) and reports win/draw/winner.
// Define CONTA_PECAS_EN to add the num_pecas occupied-cell count output.
module verificador_micro_tabuleiro
  import verificador_micro_tabuleiro_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CELL_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar_verificacao,
  input  logic [3:0]        macro_idx,
  input  logic              jogador,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic              ocupado,
  output logic              pronto_verificacao,
  output logic              micro_vencida,
  output logic              micro_empatada,
  output logic [CELL_W-1:0] vencedor,
  output logic              erro,
`ifdef CONTA_PECAS_EN
  output logic [3:0]        num_pecas,
`endif
  output logic [2:0]        db_estado
);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [3:0]        r_c;
  logic              r_jogador;
  logic [ADDR_W-1:0] r_addr;
  banco_t            r_banco;
  logic              r_vencida;
  logic              r_empatada;
  celula_t           r_vencedor;
  logic              r_erro;

  logic              w_inicio;
  logic              w_invalido;
  logic [ADDR_W-1:0] w_base;
  logic              w_vencida;
  logic              w_empatada;
  celula_t           w_vencedor;

  assign w_inicio   = (r_estado == OCIOSO) && iniciar_verificacao;
  assign w_invalido = macro_idx > 4'(NUM_CEL - 1);
  assign w_base     = ADDR_W'(macro_idx) * ADDR_W'(NUM_CEL);

  verifica_linhas u_linhas (
    .i_celulas  (r_banco),
    .i_jogador  (r_jogador),
    .o_vencida  (w_vencida),
    .o_empatada (w_empatada),
    .o_vencedor (w_vencedor)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_estado <= OCIOSO;
    else
      r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      OCIOSO:
        if (iniciar_verificacao)
          w_prox = w_invalido ? FIM : LEITURA;
      LEITURA:
        if (r_c == 4'd8)
          w_prox = CAPTURA;
      CAPTURA: w_prox = AVALIA;
      AVALIA:  w_prox = FIM;
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  // Read data trails the address by one cycle, so cell k lands while
  // the counter already points at k+1; cell 8 is caught in CAPTURA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_c        <= '0;
      r_jogador  <= 1'b0;
      r_addr     <= '0;
      r_banco    <= '0;
      r_vencida  <= 1'b0;
      r_empatada <= 1'b0;
      r_vencedor <= CELULA_VAZIA;
      r_erro     <= 1'b0;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          if (w_inicio) begin
            r_c        <= '0;
            r_jogador  <= jogador;
            r_banco    <= '0;
            r_vencida  <= 1'b0;
            r_empatada <= 1'b0;
            r_vencedor <= CELULA_VAZIA;
            r_erro     <= w_invalido;
            if (!w_invalido)
              r_addr <= w_base;
          end
        end
        LEITURA: begin
          if (r_c != 4'd0)
            r_banco[r_c - 4'd1] <= celula_t'(rd_data);
          r_c <= r_c + 4'd1;
          if (r_c != 4'd8)
            r_addr <= r_addr + ADDR_W'(1);
        end
        CAPTURA:
          r_banco[NUM_CEL-1] <= celula_t'(rd_data);
        AVALIA: begin
          r_vencida  <= w_vencida;
          r_empatada <= w_empatada;
          r_vencedor <= w_vencedor;
        end
        FIM: ;
        default: ;
      endcase
    end
  end

`ifdef CONTA_PECAS_EN
  logic [3:0] r_pecas;
  logic [3:0] w_pecas;

  always_comb begin
    w_pecas = '0;
    for (int i = 0; i < NUM_CEL; i++) begin
      if (ocupada(r_banco[i]))
        w_pecas = w_pecas + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_pecas <= '0;
    else if (w_inicio)
      r_pecas <= '0;
    else if (r_estado == AVALIA)
      r_pecas <= w_pecas;
  end

  assign num_pecas = r_pecas;
`endif

  assign rd_addr            = r_addr;
  assign ocupado            = (r_estado != OCIOSO);
  assign pronto_verificacao = (r_estado == FIM);
  assign micro_vencida      = r_vencida;
  assign micro_empatada     = r_empatada;
  assign vencedor           = CELL_W'(r_vencedor);
  assign erro               = r_erro;
  assign db_estado          = r_estado;

endmodule

// File: tb/tb_verificador_micro_tabuleiro.sv
// Bench for verificador_micro_tabuleiro: memory model, reference
// model of the tic-tac-toe rules and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_verificador_micro_tabuleiro;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar_verificacao;
  logic [3:0] macro_idx;
  logic       jogador;
  logic [6:0] rd_addr;
  logic [1:0] rd_data;
  logic       ocupado;
  logic       pronto_verificacao;
  logic       micro_vencida;
  logic       micro_empatada;
  logic [1:0] vencedor;
  logic       erro;
  logic [2:0] db_estado;
`ifdef CONTA_PECAS_EN
  logic [3:0] num_pecas;
`endif

  verificador_micro_tabuleiro dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar_verificacao (iniciar_verificacao),
    .macro_idx           (macro_idx),
    .jogador             (jogador),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .ocupado             (ocupado),
    .pronto_verificacao  (pronto_verificacao),
    .micro_vencida       (micro_vencida),
    .micro_empatada      (micro_empatada),
    .vencedor            (vencedor),
    .erro                (erro),
`ifdef CONTA_PECAS_EN
    .num_pecas           (num_pecas),
`endif
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  logic [1:0] mem [81];
  always @(posedge clock)
    rd_data <= (rd_addr < 7'd81) ? mem[rd_addr] : 2'b00;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         venc;
    bit         emp;
    logic [1:0] sym;
    bit         erro;
    int         pecas;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int checks = 0;
  int errors = 0;

  task automatic chk(string nome, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, want);
    end
  endtask

  // Reference: scan the 8 lines by start cell and stride.
  function automatic exp_t modelo(int idx, bit jog);
    exp_t e;
    bit wx, wo;
    int a, s, n, b;
    logic [1:0] c0, c1, c2;
    e = '{default: 0};
    if (idx > 8) begin
      e.erro = 1;
      return e;
    end
    wx = 0; wo = 0; n = 0; b = idx * 9;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) begin a = 3 * k; s = 1; end
      else if (k < 6) begin a = k - 3; s = 3; end
      else if (k == 6) begin a = 0; s = 4; end
      else begin a = 2; s = 2; end
      c0 = mem[b + a]; c1 = mem[b + a + s]; c2 = mem[b + a + 2 * s];
      if (c0 == c1 && c1 == c2) begin
        if (c0 == 2'b01) wx = 1;
        if (c0 == 2'b10) wo = 1;
      end
    end
    for (int i = 0; i < 9; i++)
      if (mem[b + i] == 2'b01 || mem[b + i] == 2'b10) n++;
    e.venc  = wx | wo;
    e.sym   = !e.venc ? 2'b00 : (jog ? (wo ? 2'b10 : 2'b01) : (wx ? 2'b01 : 2'b10));
    e.emp   = (n == 9) && !e.venc;
    e.pecas = n;
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && pronto_verificacao) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pronto_inesperado: got pronto at cycle %0d expected none", cyc);
      end else begin
        em = q.pop_front();
        chk("latencia", cyc, em.cyc);
        chk("micro_vencida", micro_vencida, em.venc);
        chk("micro_empatada", micro_empatada, em.emp);
        chk("vencedor", vencedor, em.sym);
        chk("erro", erro, em.erro);
`ifdef CONTA_PECAS_EN
        chk("num_pecas", num_pecas, em.pecas);
`endif
      end
    end
  end

  task automatic iniciar(int idx, bit jog);
    exp_t e;
    @(negedge clock);
    e = modelo(idx, jog);
    e.cyc = cyc + ((idx > 8) ? 1 : 12);
    q.push_back(e);
    macro_idx = 4'(idx);
    jogador = jog;
    iniciar_verificacao = 1'b1;
    @(negedge clock);
    iniciar_verificacao = 1'b0;
  endtask

  task automatic esperar_ocioso();
    int n = 0;
    while (ocupado && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_ocioso", ocupado, 0);
    @(negedge clock);
  endtask

  task automatic limpa_tab(int idx);
    for (int i = 0; i < 9; i++) mem[idx * 9 + i] = 2'b00;
  endtask

  initial begin
    logic [1:0] empate [9];
    int idx, ln;
    reset = 1'b1;
    iniciar_verificacao = 1'b0;
    macro_idx = '0;
    jogador = 1'b0;
    for (int i = 0; i < 81; i++) mem[i] = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto_verificacao, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_vencida", micro_vencida, 0);
    chk("rst_empatada", micro_empatada, 0);
    chk("rst_vencedor", vencedor, 0);
    chk("rst_erro", erro, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;

    // Board 4, row 0 = X X X
    mem[36] = 2'b01; mem[37] = 2'b01; mem[38] = 2'b01;
    iniciar(4, 0);
    for (int i = 0; i < 9; i++) begin
      chk("rd_addr_seq", rd_addr, 36 + i);
      chk("estado_leitura", db_estado, 1);
      @(negedge clock);
    end
    esperar_ocioso();

    // Board 0, anti-diagonal = O
    mem[2] = 2'b10; mem[4] = 2'b10; mem[6] = 2'b10;
    iniciar(0, 1);
    esperar_ocioso();

    // Board 8 full, no line
    empate = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 9; i++) mem[72 + i] = empate[i];
    iniciar(8, 0);
    esperar_ocioso();
    chk("resultado_mantido", micro_empatada, 1);

    // Invalid index
    iniciar(12, 1);
    esperar_ocioso();

    // Reset mid-scan aborts without pronto
    mem[27] = 2'b01; mem[31] = 2'b01; mem[35] = 2'b01;
    iniciar(3, 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ocupado", ocupado, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_estado", db_estado, 0);
    chk("abort_pronto", pronto_verificacao, 0);
    void'(q.pop_back());
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    iniciar(3, 0);
    esperar_ocioso();

    // Row with an invalid cell, plus a spurious start during the scan
    limpa_tab(5);
    mem[45] = 2'b01; mem[46] = 2'b11; mem[47] = 2'b01;
    iniciar(5, 0);
    @(negedge clock);
    macro_idx = 4'd12;
    iniciar_verificacao = 1'b1;
    @(negedge clock);
    iniciar_verificacao = 1'b0;
    esperar_ocioso();

    // Random boards, some with a forced line
    for (int t = 0; t < 60; t++) begin
      idx = $urandom_range(0, 15);
      if (idx <= 8) begin
        for (int i = 0; i < 9; i++) mem[idx * 9 + i] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) begin
          ln = $urandom_range(0, 2);
          for (int i = 0; i < 3; i++)
            mem[idx * 9 + ln * 3 + i] = 2'($urandom_range(1, 2));
          if ($urandom_range(0, 1) == 0)
            for (int i = 0; i < 3; i++)
              mem[idx * 9 + ln * 3 + i] = mem[idx * 9 + ln * 3];
        end
        if ($urandom_range(0, 3) == 0)
          for (int i = 0; i < 9; i++)
            if (mem[idx * 9 + i] == 2'b00) mem[idx * 9 + i] = 2'($urandom_range(1, 2));
      end
      iniciar(idx, 1'($urandom_range(0, 1)));
      esperar_ocioso();
    end

    repeat (3) @(negedge clock);
    chk("fila_vazia", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
